cdb_arbiter: RTL

Result-broadcast arbiter between the execution units and the reorder buffer. It shares the single common data bus (CDB) between the ALU reservation-station path and the load/store buffer. Each source gets a 2-entry FIFO, and a round-robin grant selects one result per cycle. The granted result is broadcast as (RoB index, value) to the RoB, RS and LSB wakeup logic.

---
 rtl/cdb_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter between ALU and LSB results, each behind a 2-entry FIFO
// Ports: clk_in, rst_n_in (async active-low), rdy_in (pause), flush_in (sync clear);
//        alu_*/lsb_* valid/ready result inputs {robidx, value};
//        cdb_valid/robidx/value/src_out registered broadcast (src 0 = ALU, 1 = LSB)
module cdb_arbiter #(
  parameter int ROB_ADDR = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                alu_valid_in,
  input  logic [ROB_ADDR-1:0] alu_robidx_in,
  input  logic [31:0]         alu_value_in,
  output logic                alu_ready_out,
  input  logic                lsb_valid_in,
  input  logic [ROB_ADDR-1:0] lsb_robidx_in,
  input  logic [31:0]         lsb_value_in,
  output logic                lsb_ready_out,
  output logic                cdb_valid_out,
  output logic [ROB_ADDR-1:0] cdb_robidx_out,
  output logic [31:0]         cdb_value_out,
  output logic                cdb_src_out
);
  localparam int W = ROB_ADDR + 32;
  logic [W-1:0] mem [2][2];
  logic [1:0]   cnt [2];
  logic [1:0]   rp, wp, push, pop;
  logic         last_grant, adv, any, gsel;
  logic [W-1:0] head;
  always_comb begin
    adv = rdy_in && !flush_in;
    alu_ready_out = rst_n_in && adv && !cnt[0][1];
    lsb_ready_out = rst_n_in && adv && !cnt[1][1];
    push = {lsb_valid_in && lsb_ready_out, alu_valid_in && alu_ready_out};
    any = adv && (cnt[0] != 2'd0 || cnt[1] != 2'd0);
    // LSB wins when it is the only non-empty source or when ALU went last
    gsel = cnt[1] != 2'd0 && (cnt[0] == 2'd0 || !last_grant);
    pop = any ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    head = mem[gsel][rp[gsel]];
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      rp <= '0;
      wp <= '0;
      last_grant <= 1'b1;
      cdb_valid_out <= 1'b0;
      cdb_robidx_out <= '0;
      cdb_value_out <= '0;
      cdb_src_out <= 1'b0;
    end else if (flush_in) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      rp <= '0;
      wp <= '0;
      last_grant <= 1'b1;
      cdb_valid_out <= 1'b0;
    end else if (rdy_in) begin
      cnt[0] <= cnt[0] + 2'(push[0]) - 2'(pop[0]);
      cnt[1] <= cnt[1] + 2'(push[1]) - 2'(pop[1]);
      rp <= rp ^ pop;
      wp <= wp ^ push;
      cdb_valid_out <= any;
      if (any) begin
        {cdb_robidx_out, cdb_value_out} <= head;
        cdb_src_out <= gsel;
        last_grant <= gsel;
      end
    end
  always_ff @(posedge clk_in) begin
    if (push[0]) mem[0][wp[0]] <= {alu_robidx_in, alu_value_in};
    if (push[1]) mem[1][wp[1]] <= {lsb_robidx_in, lsb_value_in};
  end
endmodule
